// File: rtl/axi_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_slave_mem
//
// AXI4 slave responder backed by an internal word-addressed RAM. It terminates
// INCR write bursts (AW/W/B) and serves INCR read bursts (AR/R). The write and
// read channels have independent FSMs, so one write burst and one read burst
// can be in flight at the same time.
//
// RAM index of an address: addr[log2(ADDR_STEP) +: MEM_AW]. Addresses wrap
// modulo the RAM depth (2**MEM_AW words of DSIZE bits).
//
// Ports
//   axi_aclk, axi_areset      clock, asynchronous active-high reset
//   axi_aw*                   write address channel (id, addr, len, valid/ready)
//   axi_w*                    write data channel (data, strb, last, valid/ready)
//   axi_b*                    write response channel (id, resp, valid/ready)
//   axi_ar*                   read address channel (id, addr, len, valid/ready)
//   axi_r*                    read data channel (id, data, resp, last, valid/ready)
//
// Build option
//   AXI_SLAVE_MEM_THROTTLE_EN  when defined, a 16-bit Galois LFSR (seed
//                              16'hACE1) throttles wready and inserts single
//                              idle cycles between read beats.
// -----------------------------------------------------------------------------
module axi_slave_mem #(
  parameter int ASIZE     = 32,
  parameter int DSIZE     = 64,
  parameter int IDSIZE    = 4,
  parameter int LSIZE     = 8,
  parameter int ADDR_STEP = 1,
  parameter int MEM_AW    = 10
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  // write address
  input  logic [IDSIZE-1:0]    axi_awid,
  input  logic [ASIZE-1:0]     axi_awaddr,
  input  logic [LSIZE-1:0]     axi_awlen,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  // write data
  input  logic [DSIZE-1:0]     axi_wdata,
  input  logic [DSIZE/8-1:0]   axi_wstrb,
  input  logic                 axi_wlast,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  // write response
  output logic [IDSIZE-1:0]    axi_bid,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  // read address
  input  logic [IDSIZE-1:0]    axi_arid,
  input  logic [ASIZE-1:0]     axi_araddr,
  input  logic [LSIZE-1:0]     axi_arlen,
  input  logic                 axi_arvalid,
  output logic                 axi_arready,
  // read data
  output logic [IDSIZE-1:0]    axi_rid,
  output logic [DSIZE-1:0]     axi_rdata,
  output logic [1:0]           axi_rresp,
  output logic                 axi_rlast,
  output logic                 axi_rvalid,
  input  logic                 axi_rready
);

  localparam int STEP_SH = $clog2(ADDR_STEP);
  localparam int NBYTES  = DSIZE / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // NOTE: the RAM has no reset; clearing it would turn the array into
  // flip-flops and the contents must survive a mid-burst reset anyway.
  logic [DSIZE-1:0] r_mem [0:(1<<MEM_AW)-1];

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_t          r_wstate;
  logic              r_awready;
  logic              r_wready_en;
  logic              r_bvalid;
  logic [IDSIZE-1:0] r_bid;
  logic [1:0]        r_bresp;
  logic [MEM_AW-1:0] r_widx;
  logic [LSIZE-1:0]  r_wlen;
  logic [LSIZE-1:0]  r_wbeat;

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_t          r_rstate;
  logic              r_arready;
  logic              r_rvalid;
  logic [IDSIZE-1:0] r_rid;
  logic [DSIZE-1:0]  r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;
  logic [MEM_AW-1:0] r_ridx;
  logic [LSIZE-1:0]  r_rlen;
  logic [LSIZE-1:0]  r_rbeat;

  logic              w_wready;
  logic              w_whs;
  logic              w_wlast_beat;
  logic [MEM_AW-1:0] w_aw_idx;
  logic [MEM_AW-1:0] w_ar_idx;
  logic              w_unused;

  // Only the index bits of the addresses matter; the rest are ignored.
  assign w_aw_idx = axi_awaddr[STEP_SH +: MEM_AW];
  assign w_ar_idx = axi_araddr[STEP_SH +: MEM_AW];
  assign w_unused = ^{axi_awaddr, axi_araddr};

`ifdef AXI_SLAVE_MEM_THROTTLE_EN
  logic [15:0] r_lfsr;

  // Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, free-running.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) r_lfsr <= 16'hACE1;
    else            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign w_wready = r_wready_en & r_lfsr[0];
`else
  assign w_wready = r_wready_en;
`endif

  assign w_whs        = axi_wvalid & w_wready;
  // Beat count is zero-based, so beat awlen+1 is the one where count == awlen.
  assign w_wlast_beat = (r_wbeat == r_wlen);

  // ---------------------------------------------------------------------------
  // RAM write port with byte enables
  // ---------------------------------------------------------------------------
  always_ff @(posedge axi_aclk) begin
    if (w_whs) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  // NOTE: all state and registered outputs use non-blocking assignments, so
  // every reader in this clock domain sees the pre-edge values.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b0;
      r_wready_en <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= '0;
      r_widx      <= '0;
      r_wlen      <= '0;
      r_wbeat     <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (axi_awvalid && r_awready) begin
            r_awready   <= 1'b0;
            r_wready_en <= 1'b1;
            r_bid       <= axi_awid;
            r_widx      <= w_aw_idx;
            r_wlen      <= axi_awlen;
            r_wbeat     <= '0;
            r_wstate    <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_whs) begin
            r_widx  <= r_widx + 1'b1;
            r_wbeat <= r_wbeat + 1'b1;
            // The burst ends on wlast or on the expected final beat, whichever
            // comes first; anything but an exact match is a protocol error.
            if (axi_wlast || w_wlast_beat) begin
              r_wready_en <= 1'b0;
              r_bvalid    <= 1'b1;
              r_bresp     <= (axi_wlast && w_wlast_beat) ? RESP_OKAY : RESP_SLVERR;
              r_wstate    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
`ifdef AXI_SLAVE_MEM_THROTTLE_EN
  logic r_rgap;
`endif

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rlast   <= 1'b0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
`ifdef AXI_SLAVE_MEM_THROTTLE_EN
      r_rgap    <= 1'b0;
`endif
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (axi_arvalid && r_arready) begin
            // First beat is fetched on the AR edge: rvalid one cycle later.
            r_arready <= 1'b0;
            r_rid     <= axi_arid;
            r_rlen    <= axi_arlen;
            r_rbeat   <= '0;
            r_rdata   <= r_mem[w_ar_idx];
            r_ridx    <= w_ar_idx + 1'b1;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= (axi_arlen == '0);
            r_rvalid  <= 1'b1;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
`ifdef AXI_SLAVE_MEM_THROTTLE_EN
          if (r_rgap) begin
            r_rvalid <= 1'b1;
            r_rgap   <= 1'b0;
          end else
`endif
          if (r_rvalid && axi_rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rstate <= R_IDLE;
            end else begin
              // Prefetch the next beat on the accepting edge for full rate.
              r_rdata <= r_mem[r_ridx];
              r_ridx  <= r_ridx + 1'b1;
              r_rbeat <= r_rbeat + 1'b1;
              r_rlast <= ((r_rbeat + 1'b1) == r_rlen);
`ifdef AXI_SLAVE_MEM_THROTTLE_EN
              if (!r_lfsr[1]) begin
                r_rvalid <= 1'b0;
                r_rgap   <= 1'b1;
              end
`endif
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign axi_awready = r_awready;
  assign axi_wready  = w_wready;
  assign axi_bid     = r_bid;
  assign axi_bresp   = r_bresp;
  assign axi_bvalid  = r_bvalid;
  assign axi_arready = r_arready;
  assign axi_rid     = r_rid;
  assign axi_rdata   = r_rdata;
  assign axi_rresp   = r_rresp;
  assign axi_rlast   = r_rlast;
  assign axi_rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_slave_mem
//
// Directed bench for axi_slave_mem with default parameters (64-bit data,
// 1024-word RAM, ADDR_STEP=1). Inputs change on the falling edge and outputs
// are sampled there, so every handshake completes on the following rising
// edge. Expected read data is written into r_exp by hand before each read.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_slave_mem;

  localparam int TMO = 50;

  logic        axi_aclk = 1'b0;
  logic        axi_areset;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [3:0]  axi_rid;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] w_vec [0:15];
  logic [63:0] r_exp [0:15];

  always #5 axi_aclk = ~axi_aclk;

  axi_slave_mem dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .axi_awid   (axi_awid),
    .axi_awaddr (axi_awaddr),
    .axi_awlen  (axi_awlen),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wlast  (axi_wlast),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_bid    (axi_bid),
    .axi_bresp  (axi_bresp),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .axi_arid   (axi_arid),
    .axi_araddr (axi_araddr),
    .axi_arlen  (axi_arlen),
    .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rid    (axi_rid),
    .axi_rdata  (axi_rdata),
    .axi_rresp  (axi_rresp),
    .axi_rlast  (axi_rlast),
    .axi_rvalid (axi_rvalid),
    .axi_rready (axi_rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Full write burst of len+1 beats from w_vec; wlast goes high on beat
  // index wlast_at (-1 = never). The burst stops at wlast or beat len.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int wlast_at, input logic [7:0] strb,
                           input logic [1:0] exp_resp);
    int n;
    @(negedge axi_aclk);
    axi_awaddr  = addr;
    axi_awlen   = 8'(len);
    axi_awid    = id;
    axi_awvalid = 1'b1;
    n = 0;
    while (!axi_awready && n < TMO) begin @(negedge axi_aclk); n++; end
    check("awready_wait", 64'(axi_awready), 1);
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      axi_wdata  = w_vec[i];
      axi_wstrb  = strb;
      axi_wlast  = (i == wlast_at);
      axi_wvalid = 1'b1;
      n = 0;
      while (!axi_wready && n < TMO) begin @(negedge axi_aclk); n++; end
      check("wready_wait", 64'(axi_wready), 1);
      @(posedge axi_aclk);
      @(negedge axi_aclk);
      if (i == wlast_at || i == len) break;
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    check("bvalid_latency", 64'(axi_bvalid), 1);
    check("wready_after_last", 64'(axi_wready), 0);
    axi_bready = 1'b1;
    n = 0;
    while (!axi_bvalid && n < TMO) begin @(negedge axi_aclk); n++; end
    check("bresp", 64'(axi_bresp), 64'(exp_resp));
    check("bid", 64'(axi_bid), 64'(id));
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_bready = 1'b0;
    check("bvalid_cleared", 64'(axi_bvalid), 0);
  endtask

  // Issue AR; returns at the falling edge after the handshake, where the
  // first beat must already be valid.
  task automatic ar_send(input logic [31:0] addr, input int len, input logic [3:0] id);
    int n;
    @(negedge axi_aclk);
    axi_araddr  = addr;
    axi_arlen   = 8'(len);
    axi_arid    = id;
    axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < TMO) begin @(negedge axi_aclk); n++; end
    check("arready_wait", 64'(axi_arready), 1);
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    axi_arvalid = 1'b0;
    check("rvalid_latency", 64'(axi_rvalid), 1);
  endtask

  // Accept nbeats beats of a len+1 beat burst, checking against r_exp.
  task automatic r_collect(input int len, input logic [3:0] id, input int nbeats);
    int n;
    axi_rready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      n = 0;
      while (!axi_rvalid && n < TMO) begin @(negedge axi_aclk); n++; end
      check("rvalid_wait", 64'(axi_rvalid), 1);
      check($sformatf("rdata[%0d]", i), axi_rdata, r_exp[i]);
      check($sformatf("rlast[%0d]", i), 64'(axi_rlast), 64'(i == len));
      check("rid", 64'(axi_rid), 64'(id));
      check("rresp", 64'(axi_rresp), 0);
      @(posedge axi_aclk);
      @(negedge axi_aclk);
    end
    axi_rready = 1'b0;
    if (nbeats == len + 1) check("rvalid_after_last", 64'(axi_rvalid), 0);
  endtask

  initial begin
    axi_areset  = 1'b1;
    axi_awid    = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
    axi_wdata   = '0; axi_wstrb  = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready  = 1'b0;
    axi_arid    = '0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0;
    axi_rready  = 1'b0;

    // Reset state
    repeat (3) @(negedge axi_aclk);
    check("rst_awready", 64'(axi_awready), 0);
    check("rst_arready", 64'(axi_arready), 0);
    check("rst_wready",  64'(axi_wready), 0);
    check("rst_bvalid",  64'(axi_bvalid), 0);
    check("rst_rvalid",  64'(axi_rvalid), 0);
    check("rst_rdata",   axi_rdata, 0);
    check("rst_rlast",   64'(axi_rlast), 0);
    check("rst_bresp",   64'(axi_bresp), 0);
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    check("idle_awready", 64'(axi_awready), 1);
    check("idle_arready", 64'(axi_arready), 1);

    // Basic 4-beat write and read-back
    for (int i = 0; i < 4; i++) w_vec[i] = 64'(i + 1);
    axi_write(32'h10, 3, 4'h5, 3, 8'hFF, 2'b00);
    r_exp[0] = 64'h1; r_exp[1] = 64'h2; r_exp[2] = 64'h3; r_exp[3] = 64'h4;
    ar_send(32'h10, 3, 4'h6);
    r_collect(3, 4'h6, 4);

    // Partial strobe: low four bytes overwritten with zero
    w_vec[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(32'h20, 0, 4'h1, 0, 8'hFF, 2'b00);
    w_vec[0] = 64'h0;
    axi_write(32'h20, 0, 4'h2, 0, 8'h0F, 2'b00);
    r_exp[0] = 64'hFFFF_FFFF_0000_0000;
    ar_send(32'h20, 0, 4'h3);
    r_collect(0, 4'h3, 1);

    // Early wlast on beat 2 of 4, then missing wlast on beat 4
    w_vec[0] = 64'hC0; w_vec[1] = 64'hC1; w_vec[2] = 64'hC2; w_vec[3] = 64'hC3;
    axi_write(32'h30, 3, 4'h7, 1, 8'hFF, 2'b10);
    r_exp[0] = 64'hC0; r_exp[1] = 64'hC1;
    ar_send(32'h30, 1, 4'h8);
    r_collect(1, 4'h8, 2);
    w_vec[0] = 64'hD0; w_vec[1] = 64'hD1; w_vec[2] = 64'hD2; w_vec[3] = 64'hD3;
    axi_write(32'h40, 3, 4'h9, -1, 8'hFF, 2'b10);

    // Concurrency: 8-beat read stalled 5 cycles while a 4-beat write completes
    for (int i = 0; i < 8; i++) w_vec[i] = 64'hA0 + 64'(i);
    axi_write(32'h100, 7, 4'h1, 7, 8'hFF, 2'b00);
    for (int i = 0; i < 8; i++) r_exp[i] = 64'hA0 + 64'(i);
    ar_send(32'h100, 7, 4'hA);
    for (int i = 0; i < 4; i++) w_vec[i] = 64'hE0 + 64'(i);
    fork
      axi_write(32'h200, 3, 4'hB, 3, 8'hFF, 2'b00);
      begin
        axi_rready = 1'b0;
        repeat (5) begin
          check("stall_rvalid", 64'(axi_rvalid), 1);
          check("stall_rdata", axi_rdata, 64'hA0);
          @(negedge axi_aclk);
        end
      end
    join
    r_collect(7, 4'hA, 8);
    for (int i = 0; i < 4; i++) r_exp[i] = 64'hE0 + 64'(i);
    ar_send(32'h200, 3, 4'hC);
    r_collect(3, 4'hC, 4);

    // Address wrap at the top of the 1024-word RAM
    for (int i = 0; i < 4; i++) w_vec[i] = 64'h5A00 + 64'(i);
    axi_write(32'h3FE, 3, 4'h2, 3, 8'hFF, 2'b00);
    for (int i = 0; i < 4; i++) r_exp[i] = 64'h5A00 + 64'(i);
    ar_send(32'h3FE, 3, 4'h2);
    r_collect(3, 4'h2, 4);
    r_exp[0] = 64'h5A02; r_exp[1] = 64'h5A03;
    ar_send(32'h0, 1, 4'h4);
    r_collect(1, 4'h4, 2);

    // Reset in the middle of a read, on beat 3 of 8
    for (int i = 0; i < 8; i++) w_vec[i] = 64'hB0 + 64'(i);
    axi_write(32'h300, 7, 4'h3, 7, 8'hFF, 2'b00);
    for (int i = 0; i < 8; i++) r_exp[i] = 64'hB0 + 64'(i);
    ar_send(32'h300, 7, 4'hD);
    r_collect(7, 4'hD, 2);
    check("mid_rdata_beat3", axi_rdata, 64'hB2);
    #1 axi_areset = 1'b1;
    #1;
    check("async_rvalid", 64'(axi_rvalid), 0);
    check("async_arready", 64'(axi_arready), 0);
    @(negedge axi_aclk);
    axi_areset = 1'b0;
    @(negedge axi_aclk);
    check("post_rst_arready", 64'(axi_arready), 1);
    ar_send(32'h300, 7, 4'hE);
    r_collect(7, 4'hE, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
